spi_sensor_scheduler: RTL
=========================

Name: spi_sensor_scheduler

Overview:
- Shares one 3-wire read-only SPI bus (scl/sdo) between N_DEV Pmod sensors, e.g. PmodALS ADC boards, each with its own chip select.
- Arbitrates level requests round-robin and runs one 16-bit read frame per grant.
- Returns the captured word tagged with the device index, then enforces a CS-high quiet gap before the next frame.
- Sits between sensor-polling logic (LED/display drivers) and the Pmod pins.

Parameters:
- N_DEV, 2, number of devices/requesters (1..8).
- CLK_DIV, 50, clk cycles per scl half-period (min 2).
- GAP_CYCLES, 1600, clk cycles cs_n stays all-high after a frame (min 1).

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous reset, active-low
- req  input  N_DEV  level request per device; bit i = read device i
- sdo  input  1  shared serial data from devices
- scl  output  1  SPI clock, idle high
- cs_n  output  N_DEV  per-device chip select, active-low, at most one low
- ack  output  N_DEV  one-cycle pulse to the served requester
- data_out  output  16  captured frame, MSB first
- data_dev  output  3  index of the device that produced data_out
- data_valid  output  1  one-cycle strobe; data_out/data_dev are valid
- busy  output  1  high in every state except IDLE

Behaviour:
- Reset (rst=0, async):
  - scl=1, cs_n=all 1, ack=0, data_out=0, data_dev=0, data_valid=0, busy=0.
  - State=IDLE, rr pointer=0.
  - Reset asserted mid-frame aborts the frame immediately; no data_valid or ack is produced.
- States: IDLE -> SETUP -> SHIFT -> HOLD -> GAP -> IDLE.
- IDLE:
  - When req!=0, grant the lowest index >= rr pointer with req set, wrapping modulo N_DEV.
  - Latch the grant index. Next cycle: cs_n[grant]=0, enter SETUP. scl stays 1.
- SETUP: hold CLK_DIV cycles, then drive scl=0 and enter SHIFT.
- SHIFT:
  - scl toggles every CLK_DIV cycles.
  - On each clk edge that drives scl 0->1, shift sdo into the shift register LSB (MSB-first frame).
  - After the 16th rising edge, enter HOLD with scl=1.
- HOLD:
  - Hold CLK_DIV cycles. On the exit edge:
    - cs_n=all 1;
    - data_out=frame and data_dev=grant;
    - data_valid=1 and ack[grant]=1, both for exactly one cycle;
    - rr pointer=grant+1 mod N_DEV;
    - enter GAP.
- GAP: hold GAP_CYCLES cycles with cs_n all high and scl=1, then return to IDLE. Requests are not sampled during GAP.
- Latency:
  - cs_n falls 1 cycle after IDLE sees req.
  - data_valid is asserted 34*CLK_DIV cycles after cs_n falls.
  - Next cs_n falls no earlier than GAP_CYCLES+1 cycles after data_valid.
- req deasserted mid-frame: the frame completes normally; ack and data_valid still pulse.
- req held continuously by one device: that device is re-served after each GAP. Other active requesters still rotate in order.
- data_out/data_dev hold their value between strobes.
- Counter widths: sized by $clog2 of CLK_DIV and GAP_CYCLES; bit counter 5 bits. No wrap occurs within a state.
- N_DEV=1: the arbiter degenerates to always granting device 0.

Optional Feature:
- Macro ALS_EXTRACT_EN.
- Defined: data_out = {8'h00, frame[12:5]}. This is the 8-bit PmodALS light value: 3 leading zeros, 8 data bits, 4 trailing zeros.
- Undefined: data_out = raw 16-bit frame.
- Timing and handshake are identical either way.

Test Plan:
- (All scenarios: CLK_DIV=4, GAP_CYCLES=20, N_DEV=2.)
- Single read:
  - Stimulus: req=01, device model shifts 16'h0A5C.
  - Response: cs_n=10 for 136 cycles; 16 scl rising edges; data_valid 1 cycle with data_out=16'h0A5C, data_dev=0; ack=01 in the same cycle.
  - With ALS_EXTRACT_EN: data_out=16'h0052.
- Round-robin:
  - Stimulus: req=11 held; device0 returns 16'h1111, device1 returns 16'h2222.
  - Response: strobes alternate dev 0,1,0,1; the gap between cs_n rising and the next cs_n falling is >=21 cycles.
- Request withdrawn mid-frame:
  - Stimulus: req=10, then req=00 during SHIFT.
  - Response: the frame completes; data_dev=1 and ack=10 pulse; busy then drops after GAP; IDLE is held with scl=1.
- Async reset mid-frame:
  - Stimulus: rst=0 at the 8th scl edge.
  - Response: same cycle, cs_n=11 and scl=1; no data_valid; after release with req=01, a full frame restarts from bit 15.
- Idle quiet:
  - Stimulus: req=00 for 500 cycles.
  - Response: scl constant 1, cs_n=11, busy=0, data_valid never asserted.

Source files
------------

// File: rtl/spi_sensor_scheduler.sv
// spi_sensor_scheduler
// Round-robin scheduler sharing one read-only 3-wire SPI bus (scl/sdo)
// between N_DEV sensors, each with its own active-low chip select.
// One 16-bit MSB-first frame is read per grant. The word is returned with
// the device index, then cs_n is held all-high for a quiet gap.
// Optional build macro: ALS_EXTRACT_EN. When it is defined, data_out
// carries the PmodALS 8-bit light value {8'h00, frame[12:5]} instead of the
// raw frame.
module spi_sensor_scheduler #(
    parameter int N_DEV      = 2,
    parameter int CLK_DIV    = 50,
    parameter int GAP_CYCLES = 1600
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_DEV-1:0] req,
    input  logic             sdo,
    output logic             scl,
    output logic [N_DEV-1:0] cs_n,
    output logic [N_DEV-1:0] ack,
    output logic [15:0]      data_out,
    output logic [2:0]       data_dev,
    output logic             data_valid,
    output logic             busy
);

    localparam int DIV_W = $clog2(CLK_DIV);
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int CNT_W = (DIV_W > GAP_W) ? DIV_W : GAP_W;
    localparam int PTR_W = (N_DEV > 1) ? $clog2(N_DEV) : 1;
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(N_DEV - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_SHIFT = 3'd2,
        ST_HOLD  = 3'd3,
        ST_GAP   = 3'd4
    } state_t;

    state_t           state_r, state_nxt_s;
    logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
    logic [4:0]       bit_r, bit_nxt_s;
    logic [15:0]      shift_r, shift_nxt_s;
    logic [PTR_W-1:0] rr_r, rr_nxt_s;
    logic [PTR_W-1:0] grant_r, grant_nxt_s;
    logic [PTR_W-1:0] pick_s;
    logic             scl_r, scl_nxt_s;
    logic [N_DEV-1:0] cs_n_r, cs_n_nxt_s;
    logic [N_DEV-1:0] ack_r, ack_nxt_s;
    logic [15:0]      data_out_r, data_out_nxt_s;
    logic [2:0]       data_dev_r, data_dev_nxt_s;
    logic             valid_r, valid_nxt_s;
    logic             busy_r;
    logic [15:0]      word_s;

    // First requester at or after the pointer, wrapping; lowest offset wins.
    function automatic logic [PTR_W-1:0] rr_pick(input logic [N_DEV-1:0] r,
                                                 input logic [PTR_W-1:0] ptr);
        logic [PTR_W-1:0] pick;
        int idx;
        pick = ptr;
        for (int k = N_DEV - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % N_DEV;
            if (r[idx]) begin
                pick = PTR_W'(idx);
            end else begin
                pick = pick;
            end
        end
        return pick;
    endfunction

    assign pick_s = rr_pick(req, rr_r);

`ifdef ALS_EXTRACT_EN
    assign word_s = {8'h00, shift_r[12:5]};
`else
    assign word_s = shift_r;
`endif

    // Next-state and next-output decode for the frame sequencer.
    always_comb begin
        state_nxt_s    = state_r;
        cnt_nxt_s      = cnt_r;
        bit_nxt_s      = bit_r;
        shift_nxt_s    = shift_r;
        rr_nxt_s       = rr_r;
        grant_nxt_s    = grant_r;
        scl_nxt_s      = scl_r;
        cs_n_nxt_s     = cs_n_r;
        ack_nxt_s      = '0;
        valid_nxt_s    = 1'b0;
        data_out_nxt_s = data_out_r;
        data_dev_nxt_s = data_dev_r;
        case (state_r)
            ST_IDLE: begin
                if (|req) begin
                    grant_nxt_s = pick_s;
                    cs_n_nxt_s  = ~(N_DEV'(1) << pick_s);
                    cnt_nxt_s   = '0;
                    bit_nxt_s   = 5'd0;
                    shift_nxt_s = 16'h0000;
                    state_nxt_s = ST_SETUP;
                end else begin
                    cnt_nxt_s = '0;
                end
            end
            ST_SETUP: begin
                if (cnt_r == DIV_LAST) begin
                    cnt_nxt_s   = '0;
                    scl_nxt_s   = 1'b0;
                    state_nxt_s = ST_SHIFT;
                end else begin
                    cnt_nxt_s = cnt_r + 1'b1;
                end
            end
            ST_SHIFT: begin
                if (cnt_r == DIV_LAST) begin
                    cnt_nxt_s = '0;
                    if (!scl_r) begin
                        // Rising scl: sample the bit the device set up on the fall.
                        scl_nxt_s   = 1'b1;
                        shift_nxt_s = {shift_r[14:0], sdo};
                        bit_nxt_s   = bit_r + 5'd1;
                    end else if (bit_r == 5'd16) begin
                        // Last high half-period done; keep scl high into HOLD.
                        state_nxt_s = ST_HOLD;
                    end else begin
                        scl_nxt_s = 1'b0;
                    end
                end else begin
                    cnt_nxt_s = cnt_r + 1'b1;
                end
            end
            ST_HOLD: begin
                if (cnt_r == DIV_LAST) begin
                    cnt_nxt_s      = '0;
                    cs_n_nxt_s     = '1;
                    data_out_nxt_s = word_s;
                    data_dev_nxt_s = 3'(grant_r);
                    valid_nxt_s    = 1'b1;
                    ack_nxt_s      = N_DEV'(1) << grant_r;
                    rr_nxt_s       = (grant_r == PTR_LAST) ? '0 : grant_r + PTR_W'(1);
                    state_nxt_s    = ST_GAP;
                end else begin
                    cnt_nxt_s = cnt_r + 1'b1;
                end
            end
            ST_GAP: begin
                if (cnt_r == GAP_LAST) begin
                    cnt_nxt_s   = '0;
                    state_nxt_s = ST_IDLE;
                end else begin
                    cnt_nxt_s = cnt_r + 1'b1;
                end
            end
            default: begin
                cnt_nxt_s   = '0;
                scl_nxt_s   = 1'b1;
                cs_n_nxt_s  = '1;
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State, counters and registered outputs; reset aborts any frame at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= ST_IDLE;
            cnt_r      <= '0;
            bit_r      <= 5'd0;
            shift_r    <= 16'h0000;
            rr_r       <= '0;
            grant_r    <= '0;
            scl_r      <= 1'b1;
            cs_n_r     <= '1;
            ack_r      <= '0;
            data_out_r <= 16'h0000;
            data_dev_r <= 3'd0;
            valid_r    <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            cnt_r      <= cnt_nxt_s;
            bit_r      <= bit_nxt_s;
            shift_r    <= shift_nxt_s;
            rr_r       <= rr_nxt_s;
            grant_r    <= grant_nxt_s;
            scl_r      <= scl_nxt_s;
            cs_n_r     <= cs_n_nxt_s;
            ack_r      <= ack_nxt_s;
            data_out_r <= data_out_nxt_s;
            data_dev_r <= data_dev_nxt_s;
            valid_r    <= valid_nxt_s;
            busy_r     <= (state_nxt_s != ST_IDLE);
        end
    end

    assign scl        = scl_r;
    assign cs_n       = cs_n_r;
    assign ack        = ack_r;
    assign data_out   = data_out_r;
    assign data_dev   = data_dev_r;
    assign data_valid = valid_r;
    assign busy       = busy_r;

endmodule
